// File: rtl/muon_trigger_multi_pkg.sv
// Shared constants, debug bit map and helpers for the N-channel muon coincidence trigger.
package muon_trigger_multi_pkg;

  localparam int NCH_DEF        = 4;
  localparam int ADC_WIDTH_DEF  = 12;
  localparam int DELAY_MAX_DEF  = 15;
  localparam int CONSEC_MAX_DEF = 7;
  localparam int OVLP_MAX_DEF   = 15;
  localparam int DEADTIME_W     = 16;
  localparam int COUNT_W        = 32;

  // DEBUG bus layout: channel 0 {above-thr, edge, widened, TRIG}
  localparam int DBG_ABV  = 3;
  localparam int DBG_EDG  = 2;
  localparam int DBG_WIDE = 1;
  localparam int DBG_TRIG = 0;

  typedef struct packed {
    logic abv;
    logic edg;
    logic wide;
  } chan_dbg_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/muon_trigger_multi_if.sv
// Config, sample and result bundle of the muon coincidence trigger.
interface muon_trigger_multi_if #(
  parameter int NCH        = 4,
  parameter int ADC_WIDTH  = 12,
  parameter int DELAY_MAX  = 15,
  parameter int CONSEC_MAX = 7,
  parameter int OVLP_MAX   = 15
);
  localparam int DLY_W = $clog2(DELAY_MAX + 1);
  localparam int CB_W  = $clog2(CONSEC_MAX + 1);
  localparam int OV_W  = $clog2(OVLP_MAX + 1);
  localparam int M_W   = $clog2(NCH + 1);

  logic [NCH*ADC_WIDTH-1:0] ADC;
  logic [NCH*ADC_WIDTH-1:0] THR;
  logic [NCH*DLY_W-1:0]     DELAY;
  logic [NCH-1:0]           CH_ENAB;
  logic [CB_W-1:0]          CONSEC_BINS;
  logic [OV_W-1:0]          COINC_OVLP;
  logic [M_W-1:0]           MULTIPLICITY;
  logic [15:0]              DEADTIME;
  logic                     TRIG;
  logic [NCH-1:0]           TRIG_PATTERN;
  logic [31:0]              TRIG_COUNT;
  logic [3:0]               DEBUG;

  modport master (
    output ADC, THR, DELAY, CH_ENAB, CONSEC_BINS, COINC_OVLP, MULTIPLICITY, DEADTIME,
    input  TRIG, TRIG_PATTERN, TRIG_COUNT, DEBUG
  );

  modport slave (
    input  ADC, THR, DELAY, CH_ENAB, CONSEC_BINS, COINC_OVLP, MULTIPLICITY, DEADTIME,
    output TRIG, TRIG_PATTERN, TRIG_COUNT, DEBUG
  );

endinterface

// File: rtl/muon_trigger_multi_chan.sv
// One trigger channel: alignment delay, threshold compare, consecutive-bin run and widening.
module muon_trig_chan
  import muon_trigger_multi_pkg::*;
#(
  parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int DELAY_MAX  = DELAY_MAX_DEF,
  parameter int CONSEC_MAX = CONSEC_MAX_DEF,
  parameter int OVLP_MAX   = OVLP_MAX_DEF,
  localparam int DLY_W = $clog2(DELAY_MAX + 1),
  localparam int CB_W  = $clog2(CONSEC_MAX + 1),
  localparam int OV_W  = $clog2(OVLP_MAX + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ADC_WIDTH-1:0] i_adc,
  input  logic [ADC_WIDTH-1:0] i_thr,
  input  logic [DLY_W-1:0]     i_dly,
  input  logic                 i_en,
  input  logic [CB_W-1:0]      i_consec,
  input  logic [OV_W-1:0]      i_ovlp,
  output logic                 o_wide,
  output chan_dbg_t            o_dbg
);
  localparam int RUN_W = $clog2(CONSEC_MAX + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(CONSEC_MAX + 1);

  logic [ADC_WIDTH-1:0] r_dly [DELAY_MAX+1];
  logic [ADC_WIDTH-1:0] w_tap;
  logic [ADC_WIDTH-1:0] r_tap_p0;
  logic                 r_abv_p1;
  logic [RUN_W-1:0]     r_run_p2;
  logic [RUN_W-1:0]     w_run_nxt;
  logic [RUN_W-1:0]     w_run_tgt;
  logic                 w_edge;
  logic                 r_edge_p2;
  logic [OV_W-1:0]      r_wcnt_p3;
  logic                 r_wide_p3;

  always_comb begin
    w_tap = '0;
    for (int i = 0; i <= DELAY_MAX; i++) begin
      if (i_dly == DLY_W'(i)) w_tap = r_dly[i];
    end
  end

  // Edge fires only on the step into CONSEC_BINS+1, so a saturated run stays quiet.
  always_comb begin
    w_run_tgt = RUN_W'(i_consec) + RUN_W'(1);
    if (!r_abv_p1)                w_run_nxt = '0;
    else if (r_run_p2 == RUN_SAT) w_run_nxt = RUN_SAT;
    else                          w_run_nxt = r_run_p2 + RUN_W'(1);
    w_edge = r_abv_p1 && (w_run_nxt == w_run_tgt) && (r_run_p2 != w_run_tgt);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= DELAY_MAX; i++) r_dly[i] <= '0;
      r_tap_p0  <= '0;
      r_abv_p1  <= 1'b0;
      r_run_p2  <= '0;
      r_edge_p2 <= 1'b0;
      r_wcnt_p3 <= '0;
      r_wide_p3 <= 1'b0;
    end else begin
      // DLY: shift line plus registered tap select
      r_dly[0] <= i_adc;
      for (int i = 1; i <= DELAY_MAX; i++) r_dly[i] <= r_dly[i-1];
      r_tap_p0 <= w_tap;
      // CMP
      r_abv_p1 <= (r_tap_p0 > i_thr) && i_en;
      // RUN
      r_run_p2  <= w_run_nxt;
      r_edge_p2 <= w_edge;
      // WIDE: a new edge reloads the counter, extending without a gap
      if (r_edge_p2) begin
        r_wcnt_p3 <= i_ovlp;
        r_wide_p3 <= 1'b1;
      end else if (r_wcnt_p3 != '0) begin
        r_wcnt_p3 <= r_wcnt_p3 - OV_W'(1);
        r_wide_p3 <= 1'b1;
      end else begin
        r_wide_p3 <= 1'b0;
      end
    end
  end

  assign o_wide     = r_wide_p3;
  assign o_dbg.abv  = r_abv_p1;
  assign o_dbg.edg  = r_edge_p2;
  assign o_dbg.wide = r_wide_p3;

endmodule

// File: rtl/muon_trigger_multi.sv
// N-channel muon coincidence trigger: per-channel hit qualification, multiplicity, pattern, count.
// Optional holdoff after each TRIG is built when MUON_TRIG_DEADTIME_EN is defined.
module muon_trigger_multi
  import muon_trigger_multi_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int DELAY_MAX  = DELAY_MAX_DEF,
  parameter int CONSEC_MAX = CONSEC_MAX_DEF,
  parameter int OVLP_MAX   = OVLP_MAX_DEF
) (
  input  logic                CLK120,
  input  logic                RESET_N,
  muon_trigger_multi_if.slave bus
);
  localparam int DLY_W = $clog2(DELAY_MAX + 1);
  localparam int CB_W  = $clog2(CONSEC_MAX + 1);
  localparam int OV_W  = $clog2(OVLP_MAX + 1);
  localparam int M_W   = $clog2(NCH + 1);

  logic [NCH*ADC_WIDTH-1:0] r_thr;
  logic [NCH*DLY_W-1:0]     r_dly;
  logic [NCH-1:0]           r_en;
  logic [CB_W-1:0]          r_consec;
  logic [OV_W-1:0]          r_ovlp;
  logic [M_W-1:0]           r_mult;
  logic [NCH-1:0]           w_wide;
  chan_dbg_t                w_dbg [NCH];
  logic [M_W-1:0]           r_sum_p4;
  logic [NCH-1:0]           r_wvec_p4;
  logic                     r_trig_p5;
  logic                     w_trig_nxt;
  logic                     w_dead_ok;
  logic [NCH-1:0]           r_pattern;
  logic [COUNT_W-1:0]       r_count;

  // Shadow config: every change lands one cycle after the port moves.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_thr    <= '0;
      r_dly    <= '0;
      r_en     <= '0;
      r_consec <= '0;
      r_ovlp   <= '0;
      r_mult   <= '0;
    end else begin
      r_thr    <= bus.THR;
      r_dly    <= bus.DELAY;
      r_en     <= bus.CH_ENAB;
      r_consec <= bus.CONSEC_BINS;
      r_ovlp   <= bus.COINC_OVLP;
      r_mult   <= bus.MULTIPLICITY;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    muon_trig_chan #(
      .ADC_WIDTH (ADC_WIDTH),
      .DELAY_MAX (DELAY_MAX),
      .CONSEC_MAX(CONSEC_MAX),
      .OVLP_MAX  (OVLP_MAX)
    ) u_chan (
      .i_clk   (CLK120),
      .i_rst_n (RESET_N),
      .i_adc   (bus.ADC[g*ADC_WIDTH +: ADC_WIDTH]),
      .i_thr   (r_thr[g*ADC_WIDTH +: ADC_WIDTH]),
      .i_dly   (r_dly[g*DLY_W +: DLY_W]),
      .i_en    (r_en[g]),
      .i_consec(r_consec),
      .i_ovlp  (r_ovlp),
      .o_wide  (w_wide[g]),
      .o_dbg   (w_dbg[g])
    );
  end

`ifdef MUON_TRIG_DEADTIME_EN
  logic [DEADTIME_W-1:0] r_dead_cfg;
  logic [DEADTIME_W-1:0] r_dead_cnt;

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dead_cfg <= '0;
      r_dead_cnt <= '0;
    end else begin
      r_dead_cfg <= bus.DEADTIME;
      if (w_trig_nxt)              r_dead_cnt <= r_dead_cfg;
      else if (r_dead_cnt != '0)   r_dead_cnt <= r_dead_cnt - DEADTIME_W'(1);
    end
  end

  assign w_dead_ok = (r_dead_cnt == '0);
`else
  logic [DEADTIME_W-1:0] w_unused_deadtime;
  assign w_unused_deadtime = bus.DEADTIME;
  assign w_dead_ok         = 1'b1;
`endif

  // The !TRIG term forbids back-to-back pulses on a held coincidence.
  assign w_trig_nxt = (r_sum_p4 >= r_mult) && (r_mult != '0) && !r_trig_p5 && w_dead_ok;

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sum_p4  <= '0;
      r_wvec_p4 <= '0;
      r_trig_p5 <= 1'b0;
      r_pattern <= '0;
      r_count   <= '0;
    end else begin
      // SUM: widened-hit vector kept alongside its popcount for the pattern
      r_sum_p4  <= M_W'(popcount16(16'(w_wide)));
      r_wvec_p4 <= w_wide;
      // TRIG
      r_trig_p5 <= w_trig_nxt;
      if (w_trig_nxt) begin
        r_pattern <= r_wvec_p4;
        r_count   <= r_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.DEBUG           = '0;
    bus.DEBUG[DBG_ABV]  = w_dbg[0].abv;
    bus.DEBUG[DBG_EDG]  = w_dbg[0].edg;
    bus.DEBUG[DBG_WIDE] = w_dbg[0].wide;
    bus.DEBUG[DBG_TRIG] = r_trig_p5;
  end

  assign bus.TRIG         = r_trig_p5;
  assign bus.TRIG_PATTERN = r_pattern;
  assign bus.TRIG_COUNT   = r_count;

endmodule

// File: tb/tb_muon_trigger_multi.sv
// Directed bench for muon_trigger_multi; expected TRIG timelines are hand-derived constants.
module tb_muon_trigger_multi;
  import muon_trigger_multi_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 12;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   exp_cnt;
  int   ntrig;
  logic [63:0] h_trig, h_abv, h_edg, h_wide;
  logic [63:0] e_trig;
  logic [63:0] hits;

  muon_trigger_multi_if #(.NCH(NCH), .ADC_WIDTH(AW), .DELAY_MAX(15), .CONSEC_MAX(7),
                          .OVLP_MAX(15)) bus ();

  muon_trigger_multi #(.NCH(NCH), .ADC_WIDTH(AW), .DELAY_MAX(15), .CONSEC_MAX(7),
                       .OVLP_MAX(15)) dut (
    .CLK120 (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] dly, input logic [3:0] en, input logic [2:0] c,
                     input logic [3:0] w, input logic [2:0] m);
    bus.DELAY        = dly;
    bus.CH_ENAB      = en;
    bus.CONSEC_BINS  = c;
    bus.COINC_OVLP   = w;
    bus.MULTIPLICITY = m;
    repeat (30) tick();
  endtask

  // Bit t of mN drives channel N to 'hi' at edge t; history bit t is sampled after edge t.
  task automatic play(input logic [63:0] m0, input logic [63:0] m1, input logic [63:0] m2,
                      input logic [63:0] m3, input logic [AW-1:0] hi);
    for (int t = 0; t < 64; t++) begin
      bus.ADC = {(m3[t] ? hi : 12'd0), (m2[t] ? hi : 12'd0),
                 (m1[t] ? hi : 12'd0), (m0[t] ? hi : 12'd0)};
      tick();
      h_trig[t] = bus.TRIG;
      h_abv[t]  = bus.DEBUG[DBG_ABV];
      h_edg[t]  = bus.DEBUG[DBG_EDG];
      h_wide[t] = bus.DEBUG[DBG_WIDE];
    end
    bus.ADC = '0;
  endtask

  task automatic expect_trig(input string tag, input logic [63:0] exp);
    chk(tag, h_trig, exp);
    exp_cnt += $countones(exp);
    chk({tag, "_count"}, 64'(bus.TRIG_COUNT), 64'(exp_cnt));
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    bus.ADC          = '0;
    bus.THR          = {4{12'd100}};
    bus.DELAY        = '0;
    bus.CH_ENAB      = '0;
    bus.CONSEC_BINS  = '0;
    bus.COINC_OVLP   = '0;
    bus.MULTIPLICITY = '0;
    bus.DEADTIME     = '0;
    repeat (3) tick();
    chk("rst_trig",    64'(bus.TRIG), 64'd0);
    chk("rst_count",   64'(bus.TRIG_COUNT), 64'd0);
    chk("rst_pattern", 64'(bus.TRIG_PATTERN), 64'd0);
    chk("rst_debug",   64'(bus.DEBUG), 64'd0);
    rst_n = 1'b1;

    // Single sample just over / at threshold
    cfg(16'h0000, 4'hF, 3'd0, 4'd0, 3'd1);
    play(64'h1, 64'h0, 64'h0, 64'h0, 12'd101);
    expect_trig("t1_over", 64'h40);
    chk("t1_dbg_abv",  h_abv,  64'h4);
    chk("t1_dbg_edg",  h_edg,  64'h8);
    chk("t1_dbg_wide", h_wide, 64'h10);
    chk("t1_pattern", 64'(bus.TRIG_PATTERN), 64'h1);
    play(64'h1, 64'h0, 64'h0, 64'h0, 12'd100);
    expect_trig("t1_equal", 64'h0);

    // Held coincidence of 8 cycles: pulses on alternate cycles
    cfg(16'h0000, 4'hF, 3'd0, 4'd7, 3'd1);
    play(64'h1, 64'h0, 64'h0, 64'h0, 12'd200);
    expect_trig("hold_alt", 64'h1540);

    // Consecutive-bin qualification on ch1
    cfg(16'h0000, 4'hF, 3'd2, 4'd0, 3'd1);
    play(64'h0, 64'h3, 64'h0, 64'h0, 12'd200);
    expect_trig("t2_two", 64'h0);
    play(64'h0, 64'h7, 64'h0, 64'h0, 12'd200);
    expect_trig("t2_three", 64'h100);
    chk("t2_pattern", 64'(bus.TRIG_PATTERN), 64'h2);
    play(64'h0, 64'h3FF, 64'h0, 64'h0, 12'd200);
    expect_trig("t2_ten", 64'h100);

    // Disabled channel never fires
    cfg(16'h0000, 4'hE, 3'd0, 4'd0, 3'd1);
    play(64'h1, 64'h0, 64'h0, 64'h0, 12'd200);
    expect_trig("ch_disabled", 64'h0);

    // Widened overlap, MULT=2
    cfg(16'h0000, 4'hF, 3'd0, 4'd3, 3'd2);
    play(64'h1, 64'h0, 64'h8, 64'h0, 12'd200);
    expect_trig("t3_overlap", 64'h200);
    chk("t3_pattern", 64'(bus.TRIG_PATTERN), 64'h5);
    play(64'h1, 64'h0, 64'h10, 64'h0, 12'd200);
    expect_trig("t3_gap", 64'h0);

    // Per-channel alignment delay
    cfg(16'h5000, 4'hF, 3'd0, 4'd0, 3'd2);
    play(64'h20, 64'h0, 64'h0, 64'h1, 12'd200);
    expect_trig("t4_aligned", 64'h800);
    chk("t4_pattern", 64'(bus.TRIG_PATTERN), 64'h9);
    cfg(16'h0005, 4'hF, 3'd0, 4'd0, 3'd2);
    play(64'h20, 64'h0, 64'h0, 64'h1, 12'd200);
    expect_trig("t4_swapped", 64'h0);

    // Multiplicity boundaries
    cfg(16'h0000, 4'hF, 3'd0, 4'd0, 3'd4);
    play(64'h1, 64'h1, 64'h1, 64'h1, 12'd200);
    expect_trig("mult_all", 64'h40);
    chk("mult_pattern", 64'(bus.TRIG_PATTERN), 64'hF);
    cfg(16'h0000, 4'hF, 3'd0, 4'd0, 3'd5);
    play(64'h1, 64'h1, 64'h1, 64'h1, 12'd200);
    expect_trig("mult_over_nch", 64'h0);
    cfg(16'h0000, 4'hF, 3'd0, 4'd0, 3'd0);
    play(64'h1, 64'h1, 64'h1, 64'h1, 12'd200);
    expect_trig("mult_zero", 64'h0);

    // Hit train every 4 cycles, DEADTIME=20
    bus.DEADTIME = 16'd20;
    cfg(16'h0000, 4'hF, 3'd0, 4'd0, 3'd1);
    hits = 64'h0000_0111_1111_1111;
`ifdef MUON_TRIG_DEADTIME_EN
    e_trig = 64'h4000_0040;
`else
    e_trig = hits << 6;
`endif
    play(hits, 64'h0, 64'h0, 64'h0, 12'd200);
    expect_trig("t5_train", e_trig);
    bus.DEADTIME = 16'd0;

    // Reset while ch0 is widened
    cfg(16'h0000, 4'hF, 3'd0, 4'd15, 3'd1);
    bus.ADC = {36'd0, 12'd200};
    tick();
    bus.ADC = '0;
    repeat (4) tick();
    chk("t6_pre_wide", 64'(bus.DEBUG[DBG_WIDE]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_trig",    64'(bus.TRIG), 64'd0);
    chk("t6_rst_count",   64'(bus.TRIG_COUNT), 64'd0);
    chk("t6_rst_pattern", 64'(bus.TRIG_PATTERN), 64'd0);
    chk("t6_rst_debug",   64'(bus.DEBUG), 64'd0);
    tick();
    rst_n = 1'b1;
    ntrig = 0;
    repeat (50) begin
      tick();
      if (bus.TRIG) ntrig++;
    end
    chk("t6_no_trig", 64'(ntrig), 64'd0);
    chk("t6_count",   64'(bus.TRIG_COUNT), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
